// File: rtl/display_scan_controller.sv
// display_scan_controller: time-multiplexed scan of DIGITS common-anode
// 7-segment digits through one shared BCD decoder, with a blanking gap
// between digits and frame-aligned updates of the displayed value.
module display_scan_controller #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned DIV    = 50000,
  parameter int unsigned BLANK  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value_in,
  output logic [3:0]            dec_out,
  output logic [DIGITS-1:0]     dig_sel,
  output logic                  blank,
  output logic                  frame
);

  localparam int unsigned VAL_W   = 4 * DIGITS;
  localparam int unsigned IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned CNT_MAX = (DIV > BLANK) ? DIV : BLANK;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [VAL_W-1:0]   shadow_q, shadow_d;
  logic [VAL_W-1:0]   active_q, active_d;
  logic               pending_q, pending_d;
  logic [3:0]         dec_out_q, dec_out_d;
  logic [DIGITS-1:0]  dig_sel_q, dig_sel_d;
  logic               blank_q, blank_d;
  logic               frame_q, frame_d;
  logic               commit;

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
      dec_out_q <= '0;
      dig_sel_q <= '1;
      blank_q   <= 1'b1;
      frame_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      dec_out_q <= dec_out_d;
      dig_sel_q <= dig_sel_d;
      blank_q   <= blank_d;
      frame_q   <= frame_d;
    end
  end

  // Scan sequencing, frame-boundary commit and next-cycle outputs.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    shadow_d  = load ? value_in : shadow_q;
    pending_d = pending_q | load;
    active_d  = active_q;
    commit    = 1'b0;
    frame_d   = 1'b0;
    dig_sel_d = '1;
    blank_d   = 1'b1;
    dec_out_d = '0;

    if (!enable) begin
      state_d = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = SHOW;
          idx_d   = '0;
          cnt_d   = '0;
          commit  = 1'b1;
        end
        SHOW: begin
          if (cnt_q == CNT_W'(DIV - 1)) begin
            state_d = GAP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        GAP: begin
          if (cnt_q == CNT_W'(BLANK - 1)) begin
            state_d = SHOW;
            cnt_d   = '0;
            if (idx_q == IDX_W'(DIGITS - 1)) begin
              idx_d   = '0;
              commit  = 1'b1;
              frame_d = 1'b1;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end

    // Commit sees the pre-edge shadow; a coincident load stays pending.
    if (commit) begin
      if (pending_q) begin
        active_d = shadow_q;
      end
      pending_d = load;
    end

    if (state_d == SHOW) begin
      dig_sel_d[idx_d] = 1'b0;
      blank_d          = 1'b0;
    end
    if (state_d != IDLE) begin
      dec_out_d = active_d[{idx_d, 2'b00} +: 4];
    end
  end

  assign dec_out = dec_out_q;
  assign dig_sel = dig_sel_q;
  assign blank   = blank_q;
  assign frame   = frame_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller with DIGITS=4, DIV=4, BLANK=2.
module tb_display_scan_controller;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned DIV    = 4;
  localparam int unsigned BLANK  = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value_in = 16'h0;
  logic [3:0]  dec_out;
  logic [3:0]  dig_sel;
  logic        blank;
  logic        frame;

  int checks = 0;
  int failures = 0;

  display_scan_controller #(
    .DIGITS(DIGITS),
    .DIV   (DIV),
    .BLANK (BLANK)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .load    (load),
    .value_in(value_in),
    .dec_out (dec_out),
    .dig_sel (dig_sel),
    .blank   (blank),
    .frame   (frame)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_dark(input string tag);
    check({tag, ".dig_sel"}, 32'(dig_sel), 32'hF);
    check({tag, ".blank"},   32'(blank),   32'h1);
    check({tag, ".dec_out"}, 32'(dec_out), 32'h0);
    check({tag, ".frame"},   32'(frame),   32'h0);
  endtask

  // Walk one full 24-cycle frame starting at the edge into digit-0 SHOW.
  // Loads are driven so they are captured on the edge beginning cycle la/lb.
  task automatic run_frame(input string tag, input logic [15:0] val, input bit wrap,
                           input int la, input logic [15:0] va,
                           input int lb, input logic [15:0] vb);
    logic [3:0] exp_sel;
    logic [3:0] exp_nib;
    int         d;
    int         p;
    for (int c = 1; c <= DIGITS * (DIV + BLANK); c++) begin
      if (c == la) begin
        load = 1'b1; value_in = va;
      end else if (c == lb) begin
        load = 1'b1; value_in = vb;
      end else begin
        load = 1'b0;
      end
      step();
      d = (c - 1) / (DIV + BLANK);
      p = (c - 1) % (DIV + BLANK);
      exp_nib = val[4*d +: 4];
      if (p < DIV) begin
        exp_sel = 4'hF;
        exp_sel[d] = 1'b0;
        check($sformatf("%s.c%0d.dig_sel", tag, c), 32'(dig_sel), 32'(exp_sel));
        check($sformatf("%s.c%0d.blank", tag, c), 32'(blank), 32'h0);
      end else begin
        check($sformatf("%s.c%0d.dig_sel", tag, c), 32'(dig_sel), 32'hF);
        check($sformatf("%s.c%0d.blank", tag, c), 32'(blank), 32'h1);
      end
      check($sformatf("%s.c%0d.dec_out", tag, c), 32'(dec_out), 32'(exp_nib));
      check($sformatf("%s.c%0d.frame", tag, c), 32'(frame),
            (c == 1 && wrap) ? 32'h1 : 32'h0);
    end
    load = 1'b0;
  endtask

  initial begin
    #1 reset = 1'b1;
    #2;
    check_dark("reset_async");
    step();
    step();
    reset = 1'b0;

    // Idle with enable low.
    for (int i = 0; i < 10; i++) begin
      step();
      check_dark($sformatf("idle%0d", i));
    end

    // Load in IDLE, then start scanning; first frame entered from IDLE.
    load = 1'b1; value_in = 16'h1234;
    step();
    load = 1'b0;
    check_dark("idle_after_load");
    enable = 1'b1;
    run_frame("f1", 16'h1234, 1'b0, 0, 16'h0, 0, 16'h0);
    // Load 0x5678 while digit 2 is lit; this frame still shows 0x1234.
    run_frame("f2", 16'h1234, 1'b1, 14, 16'h5678, 0, 16'h0);
    // Two loads in one frame; the last one wins.
    run_frame("f3", 16'h5678, 1'b1, 3, 16'h1111, 15, 16'h9999);
    // Leave 0x5678 pending for the coincident-load case.
    run_frame("f4", 16'h9999, 1'b1, 10, 16'h5678, 0, 16'h0);
    // Load 0x4321 on the edge that commits 0x5678.
    run_frame("f5", 16'h5678, 1'b1, 1, 16'h4321, 0, 16'h0);
    run_frame("f6", 16'h4321, 1'b1, 0, 16'h0, 0, 16'h0);

    // Drop enable during digit 1 SHOW.
    for (int i = 0; i < 8; i++) step();
    check("d1_show.dig_sel", 32'(dig_sel), 32'hD);
    check("d1_show.dec_out", 32'(dec_out), 32'h2);
    enable = 1'b0;
    step();
    check_dark("drop_en0");
    step();
    check_dark("drop_en1");
    enable = 1'b1;
    run_frame("f7", 16'h4321, 1'b0, 0, 16'h0, 0, 16'h0);

    // Into digit 0 GAP of the following frame, then async reset.
    for (int i = 0; i < 5; i++) step();
    check("gap.dig_sel", 32'(dig_sel), 32'hF);
    check("gap.blank",   32'(blank),   32'h1);
    check("gap.dec_out", 32'(dec_out), 32'h1);
    #1 reset = 1'b1;
    #1;
    check_dark("reset_mid_gap");
    #1 reset = 1'b0;
    // active cleared by reset: restart shows 0 on digit 0, no frame pulse.
    step();
    check("post_reset.dig_sel", 32'(dig_sel), 32'hE);
    check("post_reset.blank",   32'(blank),   32'h0);
    check("post_reset.dec_out", 32'(dec_out), 32'h0);
    check("post_reset.frame",   32'(frame),   32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
